// File: rtl/wall_bank.sv
`default_nettype none
// ============================================================================
// Module   : wall_bank
// Purpose  : Bank of scrolling walls with LFSR gap respawn, run/halt FSM, score.
// Option   : WALL_BANK_ACCEL_EN adds score-driven speed acceleration.
// Revision : 1.0
// ============================================================================
module wall_bank #(
    parameter int          WALL_NUM     = 4,
    parameter int          X_W          = 11,
    parameter int          Y_W          = 11,
    parameter int          SCREEN_W     = 640,
    parameter int          SCREEN_H     = 480,
    parameter int          WALL_SPACING = 160,
    parameter int          GAP_H        = 120,
    parameter int          Y_MIN        = 40,
    parameter int          Y_MAX        = 320,
    parameter int          RAND_W       = 9,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          SPEED_MAX    = 7
) (
    input  logic                    pixel_clk,
    input  logic                    reset,
    input  logic                    frame_tick,
    input  logic                    run,
    input  logic                    freeze,
    input  logic [2:0]              speed,
    input  logic [X_W-1:0]          player_x,
    output logic [WALL_NUM*X_W-1:0] wall_x_flat,
    output logic [WALL_NUM*Y_W-1:0] wall_y_flat,
    output logic [WALL_NUM-1:0]     respawn,
    output logic                    score_pulse,
    output logic [1:0]              state
);

    localparam logic [1:0]      c_idle      = 2'd0;
    localparam logic [1:0]      c_run       = 2'd1;
    localparam logic [1:0]      c_halt      = 2'd2;
    localparam logic [X_W-1:0]  c_cycle     = X_W'(WALL_NUM * WALL_SPACING);
    localparam logic [Y_W-1:0]  c_y_mid     = Y_W'((SCREEN_H - GAP_H) / 2);
    localparam logic [Y_W-1:0]  c_y_min     = Y_W'(Y_MIN);
    localparam logic [RAND_W:0] c_range     = (RAND_W+1)'(Y_MAX - Y_MIN + 1);
    localparam logic [3:0]      c_speed_max = 4'(SPEED_MAX);

    function automatic logic [X_W-1:0] f_reset_x(input int k);
        return X_W'(SCREEN_W + k * WALL_SPACING);
    endfunction

    logic [1:0]                        state_q, state_d;
    logic                              upd, reload;
    logic [15:0]                       lfsr_q, lfsr_d;
    logic [WALL_NUM-1:0][X_W-1:0]      x_q;
    logic [WALL_NUM-1:0][Y_W-1:0]      y_q;
    logic [WALL_NUM-1:0]               respawn_q;
    logic                              score_q;
    logic [WALL_NUM-1:0][X_W-1:0]      w_x_step;
    logic [WALL_NUM-1:0][Y_W-1:0]      w_y_new;
    logic [WALL_NUM-1:0]               w_wrap, w_pass;
    logic [3:0]                        w_sum;
    logic [2:0]                        s_eff;
    logic [X_W-1:0]                    s_x;

    // ---------------- FSM ----------------
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) state_q <= c_idle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_idle:  if (run)    state_d = c_run;
            c_run:   if (freeze) state_d = c_halt;
            c_halt:  if (!run)   state_d = c_idle;
            default:             state_d = c_idle;
        endcase
    end

    always_comb begin
        upd    = 1'b0;
        reload = 1'b0;
        state  = state_q;
        case (state_q)
            c_run:   upd    = frame_tick & ~freeze;
            c_halt:  reload = ~run;
            default: ;
        endcase
    end

    // Right-shifting Galois form of x^16+x^14+x^13+x^11.
    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    // ---------------- effective speed ----------------
`ifdef WALL_BANK_ACCEL_EN
    logic [2:0] pass_cnt_q, accel_q;

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            pass_cnt_q <= 3'd0;
            accel_q    <= 3'd0;
        end else if (reload) begin
            pass_cnt_q <= 3'd0;
            accel_q    <= 3'd0;
        end else if (upd && (|w_pass)) begin
            pass_cnt_q <= pass_cnt_q + 3'd1;
            if (pass_cnt_q == 3'd7 && accel_q != 3'd7) accel_q <= accel_q + 3'd1;
        end
    end

    assign w_sum = {1'b0, speed} + {1'b0, accel_q};
`else
    assign w_sum = {1'b0, speed};
`endif

    assign s_eff = (w_sum > c_speed_max) ? c_speed_max[2:0] : w_sum[2:0];
    assign s_x   = {{(X_W-3){1'b0}}, s_eff};

    // ---------------- per-wall datapath ----------------
    for (genvar k = 0; k < WALL_NUM; k++) begin : g_wall
        logic [RAND_W-1:0] w_cand;
        logic [RAND_W:0]   w_cand_ext, w_r;

        // Each wall draws from its own rotation so simultaneous wraps differ.
        assign w_cand     = RAND_W'((lfsr_q << k) | (lfsr_q >> (16 - k)));
        assign w_cand_ext = {1'b0, w_cand};
        assign w_r        = (w_cand_ext >= c_range) ? w_cand_ext - c_range : w_cand_ext;
        assign w_y_new[k] = c_y_min + Y_W'(w_r);

        assign w_wrap[k]   = x_q[k] < s_x;
        assign w_x_step[k] = w_wrap[k] ? x_q[k] + c_cycle - s_x : x_q[k] - s_x;
        assign w_pass[k]   = !w_wrap[k] && (x_q[k] >= player_x) && (w_x_step[k] < player_x);
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < WALL_NUM; k++) begin
                x_q[k] <= f_reset_x(k);
                y_q[k] <= c_y_mid;
            end
            respawn_q <= '0;
            score_q   <= 1'b0;
            lfsr_q    <= LFSR_SEED;
        end else begin
            lfsr_q    <= lfsr_d;
            respawn_q <= '0;
            score_q   <= 1'b0;
            if (reload) begin
                for (int k = 0; k < WALL_NUM; k++) begin
                    x_q[k] <= f_reset_x(k);
                    y_q[k] <= c_y_mid;
                end
            end else if (upd) begin
                for (int k = 0; k < WALL_NUM; k++) begin
                    x_q[k] <= w_x_step[k];
                    if (w_wrap[k]) y_q[k] <= w_y_new[k];
                end
                respawn_q <= w_wrap;
                score_q   <= |w_pass;
            end
        end
    end

    assign wall_x_flat = x_q;
    assign wall_y_flat = y_q;
    assign respawn     = respawn_q;
    assign score_pulse = score_q;

endmodule
`default_nettype wire

// File: tb/tb_wall_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_wall_bank
// Purpose  : Directed self-checking bench for wall_bank (default build).
// Revision : 1.0
// ============================================================================
module tb_wall_bank;
    localparam int WN = 4;
    localparam int XW = 11;
    localparam int YW = 11;

    logic            pixel_clk  = 1'b0;
    logic            reset      = 1'b1;
    logic            frame_tick = 1'b0;
    logic            run        = 1'b0;
    logic            freeze     = 1'b0;
    logic [2:0]      speed      = 3'd0;
    logic [XW-1:0]   player_x   = '0;
    logic [WN*XW-1:0] wall_x_flat;
    logic [WN*YW-1:0] wall_y_flat;
    logic [WN-1:0]   respawn;
    logic            score_pulse;
    logic [1:0]      state;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] lfsr_m;
    logic [15:0] lfsr_cap;
    bit          saw_resp, saw_score;

    wall_bank dut (
        .pixel_clk   (pixel_clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .run         (run),
        .freeze      (freeze),
        .speed       (speed),
        .player_x    (player_x),
        .wall_x_flat (wall_x_flat),
        .wall_y_flat (wall_y_flat),
        .respawn     (respawn),
        .score_pulse (score_pulse),
        .state       (state)
    );

    always #5 pixel_clk = ~pixel_clk;

    // Reference LFSR: free-running from seed, reloaded only by reset.
    always @(posedge pixel_clk or posedge reset) begin
        if (reset) lfsr_m <= 16'hACE1;
        else       lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    end

    function automatic int wx(input int k);
        return int'(wall_x_flat[k*XW +: XW]);
    endfunction

    function automatic int wy(input int k);
        return int'(wall_y_flat[k*YW +: YW]);
    endfunction

    function automatic int exp_y(input logic [15:0] l, input int k);
        logic [15:0] rot;
        int cand;
        rot  = (k == 0) ? l : ((l << k) | (l >> (16 - k)));
        cand = int'(rot[8:0]);
        if (cand >= 281) cand = cand - 281;
        return 40 + cand;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the update edge.
    task automatic tick(input int spd);
        speed      = 3'(spd);
        lfsr_cap   = lfsr_m;
        frame_tick = 1'b1;
        @(negedge pixel_clk);
        frame_tick = 1'b0;
        if (respawn != '0) saw_resp = 1'b1;
        if (score_pulse)   saw_score = 1'b1;
    endtask

    task automatic ticks(input int n, input int spd);
        saw_resp  = 1'b0;
        saw_score = 1'b0;
        for (int i = 0; i < n; i++) tick(spd);
    endtask

    task automatic check_home(input string tag);
        for (int k = 0; k < WN; k++) begin
            check({tag, "_x", 8'(48 + k)}, wx(k), 640 + k * 160);
            check({tag, "_y", 8'(48 + k)}, wy(k), 180);
        end
    endtask

    initial begin
        repeat (2) @(negedge pixel_clk);
        check_home("rst");
        check("rst_state", int'(state), 0);
        check("rst_respawn", int'(respawn), 0);
        check("rst_score", int'(score_pulse), 0);

        reset = 1'b0;
        @(negedge pixel_clk);
        check("idle_hold", int'(state), 0);
        run = 1'b1;
        @(negedge pixel_clk);
        check("enter_run", int'(state), 1);
        check("run_no_move", wx(0), 640);

        // Scroll: 10 frames at 4 px
        ticks(10, 4);
        check("scroll_w0", wx(0), 600);
        check("scroll_w3", wx(3), 1080);
        check("scroll_noresp", int'(saw_resp), 0);
        check("scroll_state", int'(state), 1);

        // Bring wall0 to x=2, then wrap at speed 4
        ticks(85, 7);
        check("approach_noresp", int'(saw_resp), 0);
        tick(3);
        check("pre_wrap_w0", wx(0), 2);
        check("pre_wrap_w1", wx(1), 162);
        tick(4);
        check("wrap_w0_x", wx(0), 638);
        check("wrap_respawn", int'(respawn), 1);
        check("wrap_w0_y", wy(0), exp_y(lfsr_cap, 0));
        check("wrap_y_range", int'(wy(0) >= 40 && wy(0) <= 320), 1);
        check("wrap_w1_x", wx(1), 158);
        check("wrap_no_score", int'(score_pulse), 0);
        @(negedge pixel_clk);
        check("respawn_one_cycle", int'(respawn), 0);

        // Score: wall1 158 -> 102 without passing, then 102 -> 98 passes 100
        player_x = 11'd100;
        ticks(14, 4);
        check("score_pre_x", wx(1), 102);
        check("score_pre_none", int'(saw_score), 0);
        tick(4);
        check("score_x", wx(1), 98);
        check("score_pulse", int'(score_pulse), 1);
        @(negedge pixel_clk);
        check("score_one_cycle", int'(score_pulse), 0);

        // Zero speed: no motion, no score, no respawn
        ticks(5, 0);
        check("s0_x1", wx(1), 98);
        check("s0_x0", wx(0), 578);
        check("s0_no_score", int'(saw_score), 0);
        check("s0_no_resp", int'(saw_resp), 0);

        // Freeze wins over a simultaneous frame_tick
        speed      = 3'd4;
        freeze     = 1'b1;
        frame_tick = 1'b1;
        @(negedge pixel_clk);
        frame_tick = 1'b0;
        freeze     = 1'b0;
        check("freeze_x1", wx(1), 98);
        check("freeze_state", int'(state), 2);
        @(negedge pixel_clk);
        check("halt_hold", int'(state), 2);
        run = 1'b0;
        @(negedge pixel_clk);
        check("halt_to_idle", int'(state), 0);
        check_home("reload");

        // LFSR keeps running across HALT->IDLE: next wraps follow the model
        run      = 1'b1;
        player_x = 11'd0;
        @(negedge pixel_clk);
        ticks(91, 7);
        check("wrap2_pre", wx(0), 3);
        check("wrap2_pre_noresp", int'(saw_resp), 0);
        tick(4);
        check("wrap2_x", wx(0), 639);
        check("wrap2_respawn", int'(respawn), 1);
        check("wrap2_y", wy(0), exp_y(lfsr_cap, 0));

        // Wall1 wrap uses rotation by 1
        ticks(22, 7);
        check("wrap3_pre", wx(1), 5);
        tick(7);
        check("wrap3_x", wx(1), 638);
        check("wrap3_respawn", int'(respawn), 2);
        check("wrap3_y", wy(1), exp_y(lfsr_cap, 1));
        check("wrap3_w0", wx(0), 478);

        // Asynchronous reset mid-RUN, between clock edges
        #2;
        reset = 1'b1;
        #1;
        check_home("async");
        check("async_state", int'(state), 0);
        check("async_respawn", int'(respawn), 0);
        check("async_score", int'(score_pulse), 0);
        @(negedge pixel_clk);
        reset = 1'b0;
        run   = 1'b0;
        @(negedge pixel_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/wall_bank.md
Name: wall_bank

Overview:
Parametrised successor to the single scrolling `wall` obstacle. Holds WALL_NUM walls in one block, scrolls them left by a runtime-selectable speed once per frame, and respawns walls that leave the screen with a pseudo-random gap height from an internal LFSR. Adds run/halt control, a score pulse on player pass, and per-wall respawn strobes. Sits between the frame timing generator and the renderer/collision logic, all on pixel_clk.

Parameters:
WALL_NUM, 4, number of walls
X_W, 11, x coordinate width
Y_W, 11, y coordinate width
SCREEN_W, 640, visible width; wall k reset x = SCREEN_W + k*WALL_SPACING
SCREEN_H, 480, visible height
WALL_SPACING, 160, horizontal pitch between walls
GAP_H, 120, vertical gap height
Y_MIN, 40, minimum gap top
Y_MAX, 320, maximum gap top (<= SCREEN_H - GAP_H)
RAND_W, 9, LFSR bits used per gap draw; constraint 2^RAND_W <= 2*(Y_MAX-Y_MIN+1)
LFSR_SEED, 16'hACE1, LFSR reset value (nonzero)
SPEED_MAX, 7, saturation limit for effective speed

Ports:
pixel_clk  in  1  clock
reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse per frame
run  in  1  start/continue request
freeze  in  1  halt request (collision)
speed  in  3  pixels per frame
player_x  in  X_W  player x position for scoring
wall_x_flat  out  WALL_NUM*X_W  wall k left edge at [k*X_W +: X_W]
wall_y_flat  out  WALL_NUM*Y_W  wall k gap top at [k*Y_W +: Y_W]
respawn  out  WALL_NUM  per-wall one-cycle respawn strobe
score_pulse  out  1  one-cycle pulse when any wall passes player_x
state  out  2  0=IDLE, 1=RUN, 2=HALT

Behaviour:
- Reset (async, immediate): wall_x[k] = SCREEN_W + k*WALL_SPACING; wall_y[k] = (SCREEN_H-GAP_H)/2; respawn=0; score_pulse=0; state=IDLE; LFSR=LFSR_SEED.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. Advances every pixel_clk in every state.
- FSM:
  - IDLE: walls hold; run=1 -> RUN.
  - RUN: on frame_tick, update walls; freeze=1 -> HALT.
  - HALT: walls hold; run=0 -> IDLE.
- Entering IDLE from HALT reloads reset positions and gaps. The LFSR is not reloaded.
- Simultaneous freeze and frame_tick in RUN: freeze wins, no update that cycle.
- Update, registered, visible the cycle after frame_tick. s = effective speed:
  - wall_x[k] >= s: wall_x[k] -= s.
  - wall_x[k] < s (wrap): wall_x[k] = wall_x[k] + WALL_NUM*WALL_SPACING - s, which preserves pitch exactly. respawn[k]=1 for one cycle.
  - New gap on wrap: wall_y[k] = Y_MIN + r, where cand = low RAND_W bits of the LFSR rotated left by k, RANGE = Y_MAX-Y_MIN+1, r = (cand >= RANGE) ? cand-RANGE : cand.
  - Several walls may wrap on the same tick; each uses its own rotation.
- s=0: no motion, no wrap, no score.
- score_pulse: one cycle if any wall goes from wall_x >= player_x to wall_x < player_x in an update. A wrap never scores. Multiple passes on one tick give a single pulse.
- Width rule: SCREEN_W + WALL_NUM*WALL_SPACING < 2^X_W is a parameter constraint, not checked in RTL.

Optional Feature:
WALL_BANK_ACCEL_EN
- Defined: internal accel counter increments every 8 score_pulses. Effective speed = min(speed + accel, SPEED_MAX). accel clears on reset and on entry to IDLE.
- Undefined: effective speed = min(speed, SPEED_MAX); no counter logic.

Test Plan:
- Reset: assert reset mid-RUN between edges -> outputs immediately x=640,800,960,1120; y=180 all; state=0; respawn=0.
- Scroll: run=1, speed=4, 10 frame_ticks -> wall0 x=600, wall3 x=1080; no respawn; state=1.
- Wrap: wall0 at x=2, speed=4, frame_tick -> next cycle wall0 x=638, respawn=4'b0001 for one cycle; wall0 y in [40,320]; matches reference LFSR model.
- Freeze priority: freeze=1 and frame_tick in the same cycle -> no x change, state=2. Then run=0 -> state=0, positions back to 640..1120.
- Score: player_x=100, wall1 at 102, speed=4 -> wall1 x=98, score_pulse high exactly one cycle. speed=0 for 5 ticks -> no motion, no pulse.
- ACCEL (macro defined): speed=2, 8 score events -> effective step 3. Speed saturates at 7 with speed=7 input.
